// File: rtl/loom_axil_ctrl_regs.sv
// loom_axil_ctrl_regs
// AXI-Lite register block facing the host (via the XDMA AXI-Lite master).
// Registers: ID, CTRL (finish request), IRQ_STATUS (sticky, W1C),
// IRQ_ENABLE, IRQ_RAW (live sources) and N_SCRATCH scratch words.
// Interrupt sources are edge-detected into IRQ_STATUS; irq_o is the
// registered OR of enabled status bits, finish_o a one-cycle pulse.
// Optional build macro LOOM_AXIL_TIMESTAMP_EN adds a 64-bit cycle counter
// at 0x18 (low word, latches high word) and 0x1C (latched high word).

module loom_axil_ctrl_regs #(
  parameter int          ADDR_WIDTH = 20,
  parameter int          N_IRQ      = 16,
  parameter int          N_SCRATCH  = 4,
  parameter logic [31:0] ID_VALUE   = 32'h4C4F_4F4D
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr_i,
  input  logic                  s_axil_awvalid_i,
  output logic                  s_axil_awready_o,
  input  logic [31:0]           s_axil_wdata_i,
  input  logic [3:0]            s_axil_wstrb_i,
  input  logic                  s_axil_wvalid_i,
  output logic                  s_axil_wready_o,
  output logic [1:0]            s_axil_bresp_o,
  output logic                  s_axil_bvalid_o,
  input  logic                  s_axil_bready_i,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr_i,
  input  logic                  s_axil_arvalid_i,
  output logic                  s_axil_arready_o,
  output logic [31:0]           s_axil_rdata_o,
  output logic [1:0]            s_axil_rresp_o,
  output logic                  s_axil_rvalid_o,
  input  logic                  s_axil_rready_i,
  input  logic [N_IRQ-1:0]      irq_i,
  output logic                  irq_o,
  output logic                  finish_o
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Word indices (address bits [7:2])
  localparam logic [5:0] IDX_ID       = 6'h00;
  localparam logic [5:0] IDX_CTRL     = 6'h01;
  localparam logic [5:0] IDX_STATUS   = 6'h02;
  localparam logic [5:0] IDX_ENABLE   = 6'h03;
  localparam logic [5:0] IDX_RAW      = 6'h04;
`ifdef LOOM_AXIL_TIMESTAMP_EN
  localparam logic [5:0] IDX_TS_LO    = 6'h06;
  localparam logic [5:0] IDX_TS_HI    = 6'h07;
`endif
  localparam logic [5:0] IDX_SCR_BASE = 6'h08;

  // Expand byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

  // Only bits [7:2] are decoded; anything above must be zero.
  function automatic logic upper_zero(input logic [ADDR_WIDTH-1:0] a);
    return (a >> 8) == '0;
  endfunction

  function automatic logic idx_mapped(input logic [5:0] idx);
    logic hit;
    hit = (idx == IDX_ID) || (idx == IDX_CTRL) || (idx == IDX_STATUS) ||
          (idx == IDX_ENABLE) || (idx == IDX_RAW);
`ifdef LOOM_AXIL_TIMESTAMP_EN
    hit = hit || (idx == IDX_TS_LO) || (idx == IDX_TS_HI);
`endif
    for (int i = 0; i < N_SCRATCH; i++) begin
      if (idx == IDX_SCR_BASE + 6'(i)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Channel state
  logic                  awready_q, wready_q, arready_q;
  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [31:0]           rdata_q;

  // Register state
  logic [N_IRQ-1:0]      irq_q, status_q, enable_q;
  logic [31:0]           scratch_q [N_SCRATCH];
  logic                  irq_o_q, finish_q;

  // Handshakes and next-state terms
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_have, w_have, do_write;
  logic aw_held_d, w_held_d, bvalid_d, rvalid_d;

  // Write decode
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data, wr_mask;
  logic [3:0]            wr_strb;
  logic [5:0]            wr_idx;
  logic                  wr_ok, wr_en;

  // Read decode
  logic [5:0]            rd_idx;
  logic [31:0]           rd_data;
  logic [1:0]            rd_resp;

  logic [N_IRQ-1:0]      irq_rise, status_clr;
  logic                  unused_addr_lsbs;

`ifdef LOOM_AXIL_TIMESTAMP_EN
  logic [63:0]           ts_q;
  logic [31:0]           ts_shadow_q;
`endif

  assign s_axil_awready_o = awready_q;
  assign s_axil_wready_o  = wready_q;
  assign s_axil_bvalid_o  = bvalid_q;
  assign s_axil_bresp_o   = bresp_q;
  assign s_axil_arready_o = arready_q;
  assign s_axil_rvalid_o  = rvalid_q;
  assign s_axil_rdata_o   = rdata_q;
  assign s_axil_rresp_o   = rresp_q;
  assign irq_o            = irq_o_q;
  assign finish_o         = finish_q;

  assign aw_hs = s_axil_awvalid_i & awready_q;
  assign w_hs  = s_axil_wvalid_i  & wready_q;
  assign b_hs  = bvalid_q & s_axil_bready_i;
  assign ar_hs = s_axil_arvalid_i & arready_q;
  assign r_hs  = rvalid_q & s_axil_rready_i;

  // A write commits on the edge where both address and data are available,
  // whether they were held from earlier handshakes or arrive right now.
  assign aw_have   = aw_held_q | aw_hs;
  assign w_have    = w_held_q  | w_hs;
  assign do_write  = aw_have & w_have;
  assign aw_held_d = aw_have & ~do_write;
  assign w_held_d  = w_have  & ~do_write;
  assign bvalid_d  = do_write | (bvalid_q & ~b_hs);
  assign rvalid_d  = ar_hs | (rvalid_q & ~r_hs);

  assign unused_addr_lsbs = ^{wr_addr[1:0], s_axil_araddr_i[1:0]};

  // Select held or live write address/data and decode the target.
  always_comb begin
    wr_addr = aw_held_q ? awaddr_q : s_axil_awaddr_i;
    wr_data = w_held_q  ? wdata_q  : s_axil_wdata_i;
    wr_strb = w_held_q  ? wstrb_q  : s_axil_wstrb_i;
    wr_idx  = wr_addr[7:2];
    wr_mask = lane_mask(wr_strb);
    wr_ok   = upper_zero(wr_addr) && idx_mapped(wr_idx);
    wr_en   = do_write & wr_ok;
  end

  // Read data mux from current (pre-write) register state.
  always_comb begin
    rd_idx  = s_axil_araddr_i[7:2];
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (!upper_zero(s_axil_araddr_i) || !idx_mapped(rd_idx)) begin
      rd_resp = RESP_SLVERR;
    end else begin
      case (rd_idx)
        IDX_ID:     rd_data = ID_VALUE;
        IDX_STATUS: rd_data[N_IRQ-1:0] = status_q;
        IDX_ENABLE: rd_data[N_IRQ-1:0] = enable_q;
        IDX_RAW:    rd_data[N_IRQ-1:0] = irq_i;
`ifdef LOOM_AXIL_TIMESTAMP_EN
        IDX_TS_LO:  rd_data = ts_q[31:0];
        IDX_TS_HI:  rd_data = ts_shadow_q;
`endif
        default: begin
          for (int i = 0; i < N_SCRATCH; i++) begin
            if (rd_idx == IDX_SCR_BASE + 6'(i)) rd_data = scratch_q[i];
          end
        end
      endcase
    end
  end

  // Write channel: hold AW/W independently, commit, then hold B until accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      bvalid_q  <= bvalid_d;
      awready_q <= ~aw_held_d & ~bvalid_d;
      wready_q  <= ~w_held_d  & ~bvalid_d;
      if (aw_hs) awaddr_q <= s_axil_awaddr_i;
      if (w_hs) begin
        wdata_q <= s_axil_wdata_i;
        wstrb_q <= s_axil_wstrb_i;
      end
      if (do_write) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Read channel: capture data on AR handshake, hold until R handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rvalid_q  <= rvalid_d;
      arready_q <= ~rvalid_d;
      if (ar_hs) begin
        rdata_q <= rd_data;
        rresp_q <= rd_resp;
      end
    end
  end

  // A rising source edge in the same cycle as a W1C wins over the clear.
  assign irq_rise   = irq_i & ~irq_q;
  assign status_clr = (wr_en && (wr_idx == IDX_STATUS)) ?
                      (wr_data[N_IRQ-1:0] & wr_mask[N_IRQ-1:0]) : '0;

  // Interrupt status, enable, request output and finish pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q    <= '0;
      status_q <= '0;
      enable_q <= '0;
      irq_o_q  <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      irq_q    <= irq_i;
      status_q <= (status_q & ~status_clr) | irq_rise;
      irq_o_q  <= |(status_q & enable_q);
      if (wr_en && (wr_idx == IDX_ENABLE)) begin
        enable_q <= (enable_q & ~wr_mask[N_IRQ-1:0]) |
                    (wr_data[N_IRQ-1:0] & wr_mask[N_IRQ-1:0]);
      end
      finish_q <= wr_en && (wr_idx == IDX_CTRL) && wr_data[0] && wr_strb[0];
    end
  end

  // Scratch registers, byte-lane writable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_SCRATCH; i++) scratch_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_SCRATCH; i++) begin
        if (wr_en && (wr_idx == IDX_SCR_BASE + 6'(i))) begin
          scratch_q[i] <= (scratch_q[i] & ~wr_mask) | (wr_data & wr_mask);
        end
      end
    end
  end

`ifdef LOOM_AXIL_TIMESTAMP_EN
  // Free-running cycle counter; reading the low word snapshots the high word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ts_q        <= '0;
      ts_shadow_q <= '0;
    end else begin
      ts_q <= ts_q + 64'd1;
      if (ar_hs && upper_zero(s_axil_araddr_i) && (rd_idx == IDX_TS_LO)) begin
        ts_shadow_q <= ts_q[63:32];
      end
    end
  end
`endif

endmodule
